// File: rtl/uart_tx_engine_pkg.sv
// Shared types and sizes for the UART transmit path.
package uart_tx_engine_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Pop handshake between the TX FIFO and the transmit serializer.
// master: serializer side (issues pops); slave: FIFO side (presents head data).
interface uart_tx_engine_if
  import uart_tx_engine_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) ();

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_mpty;
  logic                 fifo_rd;

  modport master (
    input  fifo_rdata,
    input  fifo_mpty,
    output fifo_rd
  );

  modport slave (
    output fifo_rdata,
    output fifo_mpty,
    input  fifo_rd
  );

endinterface

// File: rtl/uart_tx_engine_baud_gen.sv
// Bit-period timer: reloadable down-counter flagging the last cycle of each
// bit period. Shared by the transmit and (future) receive engines.
module uart_baud_gen
  import uart_tx_engine_pkg::*;
#(
  parameter int DIV_W = UART_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt;

  // Reload on restart or when a period expires, otherwise count down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= div;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bit_end = (cnt == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from the TX FIFO and frames them as
// start, LSB-first data, optional parity and one or two stop bits.
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DIV_W     = UART_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] cfg_baud_div,
  input  logic             cfg_parity_en,
  input  logic             cfg_parity_odd,
  input  logic             cfg_stop2,
  uart_tx_engine_if.master fifo,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int                IDX_W    = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_e            state;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic                 par_en_q;
  logic                 stop2_q;
  logic [DIV_W-1:0]     div_q;

  logic                 bit_end;
  logic                 last_stop;
  logic                 launch;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  // A new frame may start from idle or seamlessly on the final stop cycle
  assign last_stop    = (state == STOP) && bit_end && (stop_cnt == stop2_q);
  assign launch       = !rst && tx_en && !fifo.fifo_mpty && ((state == IDLE) || last_stop);
  assign fifo.fifo_rd = launch;

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (launch),
    .div     (launch ? cfg_baud_div : div_q),
    .bit_end (bit_end)
  );

  // Payload path: capture the popped byte and its parity, shift out per data bit
  always_ff @(posedge clk) begin
    if (launch) begin
      shift_q  <= fifo.fifo_rdata;
      parity_q <= parity_of(fifo.fifo_rdata, cfg_parity_odd);
    end else if ((state == DATA) && bit_end) begin
      shift_q  <= shift_q >> 1;
    end
  end

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      div_q    <= '0;
    end else begin
      tx_done <= last_stop;
      if (launch) begin
        state    <= START;
        tx       <= 1'b0;
        busy     <= 1'b1;
        par_en_q <= cfg_parity_en;
        stop2_q  <= cfg_stop2;
        div_q    <= cfg_baud_div;
      end else begin
        case (state)
          START: begin
            if (bit_end) begin
              state   <= DATA;
              tx      <= shift_q[0];
              bit_idx <= '0;
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bit_idx == LAST_IDX) begin
                if (par_en_q) begin
                  state <= PARITY;
                  tx    <= parity_q;
                end else begin
                  state    <= STOP;
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
                end
              end else begin
                bit_idx <= bit_idx + 1'b1;
                tx      <= shift_q[1];
              end
            end
          end
          PARITY: begin
            if (bit_end) begin
              state    <= STOP;
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
            end
          end
          STOP: begin
            if (bit_end) begin
              if (stop_cnt == stop2_q) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                stop_cnt <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine: a FIFO model feeds bytes, and every line
// cycle is compared against frames built from the UART framing rules.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic [15:0] cfg_baud_div;
  logic        cfg_parity_en;
  logic        cfg_parity_odd;
  logic        cfg_stop2;
  logic        tx;
  logic        busy;
  logic        tx_done;

  uart_tx_engine_if ifc ();

  uart_tx_engine dut (
    .clk            (clk),
    .rst            (rst),
    .tx_en          (tx_en),
    .cfg_baud_div   (cfg_baud_div),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .fifo           (ifc),
    .tx             (tx),
    .busy           (busy),
    .tx_done        (tx_done)
  );

  always #5 clk = ~clk;

  // FIFO model: array plus read/write pointers
  logic [7:0] mem [64];
  int         rd_ptr;
  int         wr_ptr;

  assign ifc.fifo_rdata = mem[rd_ptr[5:0]];
  assign ifc.fifo_mpty  = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (ifc.fifo_rd) rd_ptr <= rd_ptr + 1;
  end

  int n_checks;
  int n_fail;
  int frames_sent;
  bit exp_bits[$];

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Reference frame: start 0, data LSB first, parity from the count of ones, stop 1s
  function automatic void make_frame(input logic [7:0] b, input bit pen, input bit podd,
                                     input bit st2);
    int ones;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (pen) begin
      ones = $countones(b);
      exp_bits.push_back(podd ? (ones % 2 == 0) : (ones % 2 == 1));
    end
    exp_bits.push_back(1'b1);
    if (st2) exp_bits.push_back(1'b1);
  endfunction

  // Follows frames from the first pop until no further pop is expected.
  // en_off_at: cycle of the first frame at which tx_en is dropped (-1: never).
  // scramble: randomise cfg mid-frame to show it only matters at launch.
  task automatic run_frames(input int en_off_at, input bit scramble);
    int  waited;
    int  per;
    int  len;
    bit  exp_rd;
    frames_sent = 0;
    waited = 0;
    while (!ifc.fifo_rd && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check1("launch_seen", ifc.fifo_rd, 1'b1);
    if (!ifc.fifo_rd) return;
    while (1) begin
      make_frame(mem[rd_ptr[5:0]], cfg_parity_en, cfg_parity_odd, cfg_stop2);
      per = int'(cfg_baud_div) + 1;
      len = exp_bits.size() * per;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        check1("tx", tx, exp_bits[c / per]);
        check1("busy", busy, 1'b1);
        check1("tx_done", tx_done, (c == 0) && (frames_sent > 0));
        if (c < len - 1) check1("fifo_rd_mid", ifc.fifo_rd, 1'b0);
        if (scramble && c == 1) begin
          cfg_baud_div   = 16'($urandom_range(0, 3));
          cfg_parity_en  = 1'($urandom_range(0, 1));
          cfg_parity_odd = 1'($urandom_range(0, 1));
          cfg_stop2      = 1'($urandom_range(0, 1));
        end
        if (frames_sent == 0 && c == en_off_at) tx_en = 1'b0;
      end
      frames_sent++;
      exp_rd = tx_en && (rd_ptr != wr_ptr);
      check1("fifo_rd_end", ifc.fifo_rd, exp_rd);
      if (!exp_rd || !ifc.fifo_rd) break;
    end
    @(negedge clk);
    check1("done_pulse", tx_done, 1'b1);
    check1("busy_end", busy, 1'b0);
    check1("tx_idle", tx, 1'b1);
    @(negedge clk);
    check1("done_clear", tx_done, 1'b0);
    check1("busy_idle", busy, 1'b0);
    check1("tx_idle2", tx, 1'b1);
  endtask

  initial begin
    int per;
    int saved_ptr;
    logic [7:0] b;
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    tx_en          = 1'b1;
    cfg_baud_div   = 16'd3;
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_stop2      = 1'b0;
    push(8'hA5);

    // Reset held with data available and tx_en high
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("rst_tx", tx, 1'b1);
      check1("rst_busy", busy, 1'b0);
      check1("rst_rd", ifc.fifo_rd, 1'b0);
      check1("rst_done", tx_done, 1'b0);
    end
    checkn("rst_no_pop", rd_ptr, 0);
    tx_en = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("idle_tx", tx, 1'b1);
      check1("idle_rd", ifc.fifo_rd, 1'b0);
    end

    // Single byte 0xA5, 4-cycle bits, no parity, one stop
    tx_en = 1'b1;
    #1;
    run_frames(-1, 1'b0);
    checkn("single_frames", frames_sent, 1);
    checkn("single_pops", rd_ptr, 1);

    // Parity: 0x07 even, 0x07 odd, 0x03 even
    for (int k = 0; k < 3; k++) begin
      cfg_baud_div   = 16'($urandom_range(0, 2));
      cfg_parity_en  = 1'b1;
      cfg_parity_odd = (k == 1);
      cfg_stop2      = 1'b0;
      b = (k == 2) ? 8'h03 : 8'h07;
      push(b);
      #1;
      run_frames(-1, 1'b0);
      checkn("parity_frames", frames_sent, 1);
    end

    // Back-to-back 0x55, 0xAA with 1-cycle bits and two stop bits
    tx_en          = 1'b0;
    cfg_baud_div   = 16'd0;
    cfg_parity_en  = 1'b0;
    cfg_stop2      = 1'b1;
    push(8'h55);
    push(8'hAA);
    tx_en = 1'b1;
    #1;
    run_frames(-1, 1'b0);
    checkn("b2b_frames", frames_sent, 2);

    // Random bytes with cfg randomised mid-frame
    tx_en          = 1'b0;
    cfg_baud_div   = 16'($urandom_range(0, 3));
    cfg_parity_en  = 1'($urandom_range(0, 1));
    cfg_parity_odd = 1'($urandom_range(0, 1));
    cfg_stop2      = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) push(8'($urandom));
    tx_en = 1'b1;
    #1;
    run_frames(-1, 1'b1);
    checkn("rand_frames", frames_sent, 4);

    // tx_en dropped after the third data bit with more data waiting
    tx_en          = 1'b0;
    cfg_baud_div   = 16'd1;
    cfg_parity_en  = 1'b0;
    cfg_stop2      = 1'b0;
    push(8'($urandom));
    push(8'($urandom));
    tx_en = 1'b1;
    #1;
    run_frames(4 * 2, 1'b0);
    checkn("en_off_frames", frames_sent, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("en_off_tx", tx, 1'b1);
      check1("en_off_rd", ifc.fifo_rd, 1'b0);
    end
    checkn("en_off_left", wr_ptr - rd_ptr, 1);

    // Reset during data bit 5, then the next byte goes out cleanly
    push(8'($urandom));
    per   = int'(cfg_baud_div) + 1;
    b     = mem[rd_ptr[5:0]];
    tx_en = 1'b1;
    #1;
    begin
      int waited = 0;
      while (!ifc.fifo_rd && waited < 40) begin
        @(negedge clk);
        waited++;
      end
    end
    check1("rst_launch", ifc.fifo_rd, 1'b1);
    for (int i = 0; i < 6 * per + 1; i++) @(negedge clk);
    check1("bit5_tx", tx, b[5]);
    saved_ptr = rd_ptr;
    rst = 1'b1;
    #1;
    check1("midrst_tx", tx, 1'b1);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_rd", ifc.fifo_rd, 1'b0);
    @(negedge clk);
    check1("midrst_rd2", ifc.fifo_rd, 1'b0);
    checkn("midrst_nopop", rd_ptr, saved_ptr);
    rst = 1'b0;
    #1;
    run_frames(-1, 1'b0);
    checkn("post_rst_frames", frames_sent, 1);
    checkn("post_rst_empty", wr_ptr - rd_ptr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
